// File: rtl/dead_time_gen_if.sv
// Gate-drive bundle for dead_time_gen: PWM command and enable in, complementary drives out.
// Handshake: none -- all inputs are levels sampled on every rising clk edge; outputs are registered levels.
interface dead_time_gen_if #(
  parameter int DT_W = 8
);
  logic            ena;
  logic            in;
  logic [DT_W-1:0] dead_ticks;
  logic            out_hi;
  logic            out_lo;
  logic            in_dead;
  logic [4:0]      state_dbg;

  modport master (
    output ena, in, dead_ticks,
    input  out_hi, out_lo, in_dead, state_dbg
  );

  modport slave (
    input  ena, in, dead_ticks,
    output out_hi, out_lo, in_dead, state_dbg
  );
endinterface

// File: rtl/dead_time_gen.sv
// Complementary gate-drive generator with programmable break-before-make dead time.
// Optional macro DEAD_TIME_SYNC_EN adds a 2-flop synchroniser on the PWM command input.
module dead_time_gen #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  dead_time_gen_if.slave  bus
);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_HI_ON   = 5'b00010,
    S_DEAD_HL = 5'b00100,
    S_LO_ON   = 5'b01000,
    S_DEAD_LH = 5'b10000
  } state_e;

  state_e          state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic [DT_W-1:0] dt_lat_q, dt_lat_d;
  logic            from_idle_q, from_idle_d;
  logic            in_q, in_d;
  logic [DT_W-1:0] dt_eff;

`ifdef DEAD_TIME_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.in;
      sync2_q <= sync1_q;
    end
  end

  assign in_d = sync2_q;
`else
  assign in_d = bus.in;
`endif

  assign dt_eff = (bus.dead_ticks == '0) ? DT_W'(1) : bus.dead_ticks;

  // A dead phase entered from IDLE has no side that was on, so a level change
  // restarts the count in the opposite dead state instead of reverting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dt_lat_d    = dt_lat_q;
    from_idle_d = from_idle_q;
    if (!bus.ena) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      from_idle_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d     = in_q ? S_DEAD_LH : S_DEAD_HL;
          cnt_d       = DT_W'(1);
          dt_lat_d    = dt_eff;
          from_idle_d = 1'b1;
        end
        S_HI_ON: begin
          if (!in_q) begin
            state_d     = S_DEAD_HL;
            cnt_d       = DT_W'(1);
            dt_lat_d    = dt_eff;
            from_idle_d = 1'b0;
          end
        end
        S_LO_ON: begin
          if (in_q) begin
            state_d     = S_DEAD_LH;
            cnt_d       = DT_W'(1);
            dt_lat_d    = dt_eff;
            from_idle_d = 1'b0;
          end
        end
        S_DEAD_HL: begin
          if (in_q) begin
            if (from_idle_q) begin
              state_d  = S_DEAD_LH;
              cnt_d    = DT_W'(1);
              dt_lat_d = dt_eff;
            end else begin
              state_d = S_HI_ON;
              cnt_d   = '0;
            end
          end else if (cnt_q == dt_lat_q) begin
            state_d = S_LO_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DT_W'(1);
          end
        end
        S_DEAD_LH: begin
          if (!in_q) begin
            if (from_idle_q) begin
              state_d  = S_DEAD_HL;
              cnt_d    = DT_W'(1);
              dt_lat_d = dt_eff;
            end else begin
              state_d = S_LO_ON;
              cnt_d   = '0;
            end
          end else if (cnt_q == dt_lat_q) begin
            state_d = S_HI_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dt_lat_q    <= '0;
      from_idle_q <= 1'b0;
      in_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dt_lat_q    <= dt_lat_d;
      from_idle_q <= from_idle_d;
      in_q        <= in_d;
    end
  end

  // Outputs come straight from one-hot state flops, so they can never overlap.
  assign bus.out_hi    = state_q[1];
  assign bus.out_lo    = state_q[3];
  assign bus.in_dead   = state_q[2] | state_q[4];
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_dead_time_gen.sv
// Self-checking bench for dead_time_gen: directed timing scenarios plus a random invariant run.
module tb_dead_time_gen;

`ifdef DEAD_TIME_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [2:0] exp_q[$];
  logic [2:0] got;
  logic [2:0] exp;

  dead_time_gen_if #(.DT_W(8)) bus ();

  dead_time_gen #(.DT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive_cycle(input logic r, input logic e, input logic i, input logic [7:0] d);
    rst            = r;
    bus.ena        = e;
    bus.in         = i;
    bus.dead_ticks = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) exp_q.push_back(3'b000);
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 8'd3);
      got = {bus.out_hi, bus.out_lo, bus.in_dead};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", c, got, exp);
      end
      checks++;
      if (bus.state_dbg !== 5'b00001) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%b exp=00001", c, bus.state_dbg);
      end
    end
  endtask

  task automatic test_startup();
    for (int c = 0; c < L + 8; c++) exp_q.push_back((c < L + 3) ? 3'b001 : 3'b100);
    for (int c = 0; c < L + 8; c++) begin
      drive_cycle(1'b1, 1'b1, 1'b1, 8'd3);
      got = {bus.out_hi, bus.out_lo, bus.in_dead};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL startup_lh cyc=%0d got=%b exp=%b", c, got, exp);
      end
    end
    for (int c = 0; c < L + 7; c++)
      exp_q.push_back((c < L) ? 3'b100 : (c < L + 3) ? 3'b001 : 3'b010);
    for (int c = 0; c < L + 7; c++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 8'd3);
      got = {bus.out_hi, bus.out_lo, bus.in_dead};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL startup_hl cyc=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_reversion();
    for (int c = 0; c < L + 13; c++)
      exp_q.push_back((c < L) ? 3'b010 : (c < L + 10) ? 3'b001 : 3'b100);
    for (int c = 0; c < L + 13; c++) begin
      drive_cycle(1'b1, 1'b1, 1'b1, 8'd10);
      got = {bus.out_hi, bus.out_lo, bus.in_dead};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL dt10_lh cyc=%0d got=%b exp=%b", c, got, exp);
      end
    end
    for (int c = 0; c < L + 9; c++)
      exp_q.push_back((c < L) ? 3'b100 : (c < L + 4) ? 3'b001 : 3'b100);
    for (int c = 0; c < L + 9; c++) begin
      drive_cycle(1'b1, 1'b1, (c < 4) ? 1'b0 : 1'b1, 8'd10);
      got = {bus.out_hi, bus.out_lo, bus.in_dead};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reversion cyc=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_ena();
    for (int c = 0; c < 8; c++)
      exp_q.push_back((c == 0) ? 3'b000 : (c < 4) ? 3'b001 : 3'b100);
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1'b1, (c != 0), 1'b1, 8'd3);
      got = {bus.out_hi, bus.out_lo, bus.in_dead};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL ena_drop cyc=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_dt_latch();
    for (int c = 0; c < L + 7; c++)
      exp_q.push_back((c < L) ? 3'b100 : (c < L + 4) ? 3'b001 : 3'b010);
    for (int c = 0; c < L + 7; c++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, (c <= L) ? 8'd4 : 8'd1);
      got = {bus.out_hi, bus.out_lo, bus.in_dead};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL dt_latch cyc=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_dt0();
    for (int c = 0; c < L + 4; c++)
      exp_q.push_back((c < L) ? 3'b010 : (c == L) ? 3'b001 : 3'b100);
    for (int c = 0; c < L + 4; c++) begin
      drive_cycle(1'b1, 1'b1, 1'b1, 8'd0);
      got = {bus.out_hi, bus.out_lo, bus.in_dead};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL dt0_lh cyc=%0d got=%b exp=%b", c, got, exp);
      end
    end
    for (int c = 0; c < L + 4; c++)
      exp_q.push_back((c < L) ? 3'b100 : (c == L) ? 3'b001 : 3'b010);
    for (int c = 0; c < L + 4; c++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 8'd0);
      got = {bus.out_hi, bus.out_lo, bus.in_dead};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL dt0_hl cyc=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  // Dead time is held per segment; each segment opens with ena low so the new value applies cleanly.
  task automatic test_random();
    logic [7:0] dt_v;
    int         dt_eff;
    int         hold;
    int         last_on;
    int         low_cnt;
    logic       cur_in;
    logic       ena_v;
    last_on = 0;
    low_cnt = 0;
    cur_in  = 1'b0;
    hold    = 0;
    for (int seg = 0; seg < 8; seg++) begin
      dt_v   = 8'($urandom_range(0, 6));
      dt_eff = (dt_v == 8'd0) ? 1 : int'(dt_v);
      for (int c = 0; c < 1250; c++) begin
        ena_v = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
        if (hold == 0) begin
          cur_in = ~cur_in;
          hold   = $urandom_range(1, 12);
        end
        hold--;
        drive_cycle(1'b1, ena_v, cur_in, dt_v);
        checks++;
        if (bus.out_hi && bus.out_lo) begin
          failures++;
          $display("FAIL overlap seg=%0d cyc=%0d got=11 exp=not_both", seg, c);
        end
        if (bus.out_hi) begin
          if (last_on == 2) begin
            checks++;
            if (low_cnt < dt_eff) begin
              failures++;
              $display("FAIL low_time_lh seg=%0d cyc=%0d got=%0d exp>=%0d", seg, c, low_cnt, dt_eff);
            end
          end
          last_on = 1;
          low_cnt = 0;
        end else if (bus.out_lo) begin
          if (last_on == 1) begin
            checks++;
            if (low_cnt < dt_eff) begin
              failures++;
              $display("FAIL low_time_hl seg=%0d cyc=%0d got=%0d exp>=%0d", seg, c, low_cnt, dt_eff);
            end
          end
          last_on = 2;
          low_cnt = 0;
        end else begin
          low_cnt++;
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_startup();
    test_reversion();
    test_ena();
    test_dt_latch();
    test_dt0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
